// File: rtl/seg7_mux_scan.sv
// Time-multiplexed N-digit 7-segment driver. It double-buffers the display value,
// decodes hex or BCD, blanks leading zeros, and applies output polarity at the output registers.
module seg7_mux_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1024,
  parameter int DIV_W          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] PCNT_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [DIV_W-1:0]    pcnt_reg, pcnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] active_reg, active_next, pending_reg;
  logic [DIGITS-1:0]   act_dp_reg, act_dp_next, pend_dp_reg;
  logic                pend_reg;
  logic [6:0]          seg_reg;
  logic                seg_dp_reg;
  logic [DIGITS-1:0]   dig_sel_reg;
  logic                frame_start_reg;

  logic tick, wrap, swap;
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] lz_blank;
  logic [3:0]        nib_sel;
  logic [6:0]        seg_act;

  assign tick = ena && (pcnt_reg == PCNT_LAST);
  assign wrap = tick && (idx_reg == IDX_LAST);
  assign swap = wrap && pend_reg;

  always_comb begin
    pcnt_next = pcnt_reg;
    if (ena)
      pcnt_next = (pcnt_reg == PCNT_LAST) ? '0 : pcnt_reg + 1'b1;
    idx_next = idx_reg;
    if (tick)
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    active_next = swap ? pending_reg : active_reg;
    act_dp_next = swap ? pend_dp_reg : act_dp_reg;
  end

  // Digit k>0 blanks when it and every more-significant nibble are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib[gi] = active_next[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign lz_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lz_blank[gi] = blank_lz && (active_next[4*DIGITS-1:4*gi] == '0);
    end
  end

  // Decode the digit that will be shown after this edge so outputs track idx without lag.
  always_comb begin
    nib_sel = nib[idx_next];
    case (nib_sel)
      4'h0: seg_act = 7'h3F;
      4'h1: seg_act = 7'h06;
      4'h2: seg_act = 7'h5B;
      4'h3: seg_act = 7'h4F;
      4'h4: seg_act = 7'h66;
      4'h5: seg_act = 7'h6D;
      4'h6: seg_act = 7'h7D;
      4'h7: seg_act = 7'h07;
      4'h8: seg_act = 7'h7F;
      4'h9: seg_act = 7'h6F;
      4'hA: seg_act = 7'h77;
      4'hB: seg_act = 7'h7C;
      4'hC: seg_act = 7'h39;
      4'hD: seg_act = 7'h5E;
      4'hE: seg_act = 7'h79;
      default: seg_act = 7'h71;
    endcase
    if ((!hex_mode && nib_sel > 4'd9) || lz_blank[idx_next])
      seg_act = 7'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_reg    <= '0;
      idx_reg     <= '0;
      active_reg  <= '0;
      act_dp_reg  <= '0;
      pending_reg <= '0;
      pend_dp_reg <= '0;
      pend_reg    <= 1'b0;
    end else begin
      pcnt_reg   <= pcnt_next;
      idx_reg    <= idx_next;
      active_reg <= active_next;
      act_dp_reg <= act_dp_next;
      // A load in the swap cycle lands after the swap consumed the old pending.
      if (load) begin
        pending_reg <= value;
        pend_dp_reg <= dp;
        pend_reg    <= 1'b1;
      end else if (swap) begin
        pend_reg    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      seg_reg         <= SEG_OFF;
      seg_dp_reg      <= SEG_ACTIVE_LOW;
      dig_sel_reg     <= DIG_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      seg_reg         <= seg_act ^ SEG_OFF;
      seg_dp_reg      <= act_dp_next[idx_next] ^ SEG_ACTIVE_LOW;
      dig_sel_reg     <= (DIGITS'(1) << idx_next) ^ DIG_OFF;
      frame_start_reg <= wrap;
    end
  end

  assign seg         = seg_reg;
  assign seg_dp      = seg_dp_reg;
  assign dig_sel     = dig_sel_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_mux_scan.sv
// Directed bench for seg7_mux_scan: an active-high and an active-low instance share one stimulus,
// and the bench checks scan order, decoding, buffering, ena gating and reset.
module tb_seg7_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n, ena, load, hex_mode, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg, seg_n;
  logic        seg_dp, seg_dp_n, frame_start, frame_start_n;
  logic [3:0]  dig_sel, dig_sel_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_mux_scan #(.DIGITS(4), .REFRESH_DIV(4), .DIV_W(4),
                  .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .value(value), .dp(dp),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg(seg), .seg_dp(seg_dp),
    .dig_sel(dig_sel), .frame_start(frame_start));

  seg7_mux_scan #(.DIGITS(4), .REFRESH_DIV(4), .DIV_W(4),
                  .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .value(value), .dp(dp),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg(seg_n), .seg_dp(seg_dp_n),
    .dig_sel(dig_sel_n), .frame_start(frame_start_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (frame_start) break;
    end
    check(tag, {31'd0, frame_start}, 32'd1);
  endtask

  initial begin
    int fs_count;
    rst_n = 1'b0; ena = 1'b1; load = 1'b0; value = '0; dp = '0;
    hex_mode = 1'b1; blank_lz = 1'b0;

    // Reset state, both polarities
    step(3);
    check("rst_seg",     {25'd0, seg},       32'h00);
    check("rst_dp",      {31'd0, seg_dp},    32'h0);
    check("rst_dig",     {28'd0, dig_sel},   32'h0);
    check("rst_fs",      {31'd0, frame_start}, 32'h0);
    check("rst_seg_n",   {25'd0, seg_n},     32'h7F);
    check("rst_dp_n",    {31'd0, seg_dp_n},  32'h1);
    check("rst_dig_n",   {28'd0, dig_sel_n}, 32'hF);
    rst_n = 1'b1;
    step(1);
    check("first_dig",   {28'd0, dig_sel},   32'h1);
    check("first_seg",   {25'd0, seg},       32'h3F);

    // Polarity with digit value 8
    do_load(16'h0008, 4'b0000);
    wait_frame("pol_frame");
    check("pol_seg_n",   {25'd0, seg_n},     32'h00);
    check("pol_dig_n",   {28'd0, dig_sel_n}, 32'hE);
    check("pol_dp_n",    {31'd0, seg_dp_n},  32'h1);
    check("pol_seg",     {25'd0, seg},       32'h7F);

    // Hex scan of 1A2F with dp on digit 2
    do_load(16'h1A2F, 4'b0100);
    wait_frame("scan_frame");
    check("scan_d0_dig", {28'd0, dig_sel},   32'h1);
    check("scan_d0_seg", {25'd0, seg},       32'h71);
    check("scan_d0_dp",  {31'd0, seg_dp},    32'h0);
    fs_count = 0;
    step(4);
    check("scan_d1_dig", {28'd0, dig_sel},   32'h2);
    check("scan_d1_seg", {25'd0, seg},       32'h5B);
    step(4);
    check("scan_d2_dig", {28'd0, dig_sel},   32'h4);
    check("scan_d2_seg", {25'd0, seg},       32'h77);
    check("scan_d2_dp",  {31'd0, seg_dp},    32'h1);
    step(4);
    check("scan_d3_dig", {28'd0, dig_sel},   32'h8);
    check("scan_d3_seg", {25'd0, seg},       32'h06);
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (frame_start) fs_count++;
    end
    check("scan_fs_once", fs_count,          32'd1);
    check("scan_wrap_dig", {28'd0, dig_sel}, 32'h1);

    // BCD with leading-zero blanking
    hex_mode = 1'b0; blank_lz = 1'b1;
    do_load(16'h0007, 4'b0000);
    wait_frame("bcd_frame");
    check("lz_d0",       {25'd0, seg},       32'h07);
    step(4);
    check("lz_d1",       {25'd0, seg},       32'h00);
    step(4);
    check("lz_d2",       {25'd0, seg},       32'h00);
    step(4);
    check("lz_d3",       {25'd0, seg},       32'h00);
    do_load(16'h00C5, 4'b0000);
    wait_frame("bcd2_frame");
    check("bcd_d0",      {25'd0, seg},       32'h6D);
    step(4);
    check("bcd_d1_dig",  {28'd0, dig_sel},   32'h2);
    check("bcd_d1",      {25'd0, seg},       32'h00);

    // Tear-free update
    hex_mode = 1'b1; blank_lz = 1'b0;
    do_load(16'h2222, 4'b0000);
    wait_frame("tear_frame");
    step(8);
    check("tear_d2_dig", {28'd0, dig_sel},   32'h4);
    do_load(16'h1111, 4'b0000);
    check("tear_d2_old", {25'd0, seg},       32'h5B);
    step(3);
    check("tear_d3_dig", {28'd0, dig_sel},   32'h8);
    check("tear_d3_old", {25'd0, seg},       32'h5B);
    step(4);
    check("tear_wrap_fs", {31'd0, frame_start}, 32'h1);
    check("tear_d0_new", {25'd0, seg},       32'h06);
    step(4);
    check("tear_d1_new", {25'd0, seg},       32'h06);
    do_load(16'h3333, 4'b0000);
    step(10);
    value = 16'h4444; load = 1'b1;
    step(1);
    load = 1'b0;
    check("swapcyc_fs",  {31'd0, frame_start}, 32'h1);
    check("swapcyc_old", {25'd0, seg},       32'h4F);
    step(16);
    check("swapcyc_fs2", {31'd0, frame_start}, 32'h1);
    check("swapcyc_new", {25'd0, seg},       32'h66);

    // ena gating at idx 1
    step(4);
    check("ena_d1_dig",  {28'd0, dig_sel},   32'h2);
    ena = 1'b0;
    step(1);
    check("ena_off_dig", {28'd0, dig_sel},   32'h0);
    check("ena_off_seg", {25'd0, seg},       32'h00);
    check("ena_off_dign", {28'd0, dig_sel_n}, 32'hF);
    step(2);
    check("ena_hold_dig", {28'd0, dig_sel},  32'h0);
    ena = 1'b1;
    step(1);
    check("ena_on_dig",  {28'd0, dig_sel},   32'h2);
    check("ena_on_seg",  {25'd0, seg},       32'h66);
    step(2);
    check("ena_hold_d1", {28'd0, dig_sel},   32'h2);
    step(1);
    check("ena_adv_d2",  {28'd0, dig_sel},   32'h4);

    // Mid-frame reset at idx 3 with a pending load
    step(4);
    check("mrst_d3_dig", {28'd0, dig_sel},   32'h8);
    do_load(16'h5555, 4'b0000);
    rst_n = 1'b0;
    step(1);
    check("mrst_dig",    {28'd0, dig_sel},   32'h0);
    check("mrst_seg",    {25'd0, seg},       32'h00);
    rst_n = 1'b1;
    step(1);
    check("mrst_rel_dig", {28'd0, dig_sel},  32'h1);
    check("mrst_rel_seg", {25'd0, seg},      32'h3F);
    wait_frame("mrst_frame");
    check("mrst_no_pend", {25'd0, seg},      32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
